// File: rtl/sad_controller.sv
// SAD sequencer: fetches NUM_PIXELS cur/ref pixel pairs from synchronous memories
// and accumulates |cur - ref| into a saturating sum, reported with start/busy/done.

module sad_abs (
   input  logic [15:0] value,
   output logic [15:0] mag
);
   logic [15:0] negated;

   assign negated = ~value + 16'd1;
   assign mag     = value[15] ? negated : value;
endmodule

module sad_controller #(
   parameter int PIXEL_W    = 8,
   parameter int NUM_PIXELS = 16,
   parameter int ADDR_W     = 4,
   parameter int SUM_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               mem_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIXEL_W-1:0] cur_pix,
   input  logic [PIXEL_W-1:0] ref_pix,
   output logic               busy,
   output logic               done,
   output logic [SUM_W-1:0]   sad
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int EXT_W = ((SUM_W > 16) ? SUM_W : 16) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   logic [1:0]       state_reg;
   logic [SUM_W-1:0] acc_reg;
   logic [SUM_W-1:0] acc_next;
   logic             valid_reg;
   logic [15:0]      diff;
   logic [15:0]      mag;
   logic [EXT_W-1:0] sum_ext;
   logic             overflow;

   assign diff = 16'(cur_pix) - 16'(ref_pix);

   sad_abs u_abs (
      .value (diff),
      .mag   (mag)
   );

   // Widened add so the carry out of SUM_W bits is visible for saturation.
   assign sum_ext  = EXT_W'(acc_reg) + EXT_W'(mag);
   assign overflow = |sum_ext[EXT_W-1:SUM_W];
   assign acc_next = overflow ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

   assign busy = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
   assign done = (state_reg == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         acc_reg   <= '0;
         valid_reg <= 1'b0;
         sad       <= '0;
      end else begin
         // Read data lags mem_en by one cycle; this alone decides accumulation.
         valid_reg <= mem_en;
         if (valid_reg) begin
            acc_reg <= acc_next;
         end

         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg <= ST_FETCH;
                  mem_en    <= 1'b1;
                  mem_addr  <= '0;
                  acc_reg   <= '0;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (mem_addr == LAST_ADDR) begin
                  mem_en    <= 1'b0;
                  state_reg <= ST_DRAIN;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
               end
            end
            ST_DRAIN: begin
               state_reg <= ST_DONE;
               sad       <= valid_reg ? acc_next : acc_reg;
            end
            default: begin
               state_reg <= ST_IDLE;
               mem_en    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sad_controller.sv
// Scoreboard bench for sad_controller: per-cycle handshake/address checks plus
// queued expected SAD values compared whenever done pulses.

module tb_sad_controller;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic       start8;
   logic       mem_en, mem_en8;
   logic [3:0] mem_addr, mem_addr8;
   logic [7:0] cur_pix, ref_pix, cur_pix8, ref_pix8;
   logic       busy, busy8;
   logic       done, done8;
   logic [15:0] sad;
   logic [7:0]  sad8;

   logic [7:0] cur_mem [16];
   logic [7:0] ref_mem [16];

   int checks   = 0;
   int failures = 0;
   int sb_q [$];

   sad_controller #(.PIXEL_W(8), .NUM_PIXELS(16), .ADDR_W(4), .SUM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_en(mem_en), .mem_addr(mem_addr),
      .cur_pix(cur_pix), .ref_pix(ref_pix), .busy(busy), .done(done), .sad(sad)
   );

   sad_controller #(.PIXEL_W(8), .NUM_PIXELS(16), .ADDR_W(4), .SUM_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .mem_en(mem_en8), .mem_addr(mem_addr8),
      .cur_pix(cur_pix8), .ref_pix(ref_pix8), .busy(busy8), .done(done8), .sad(sad8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         cur_pix <= cur_mem[mem_addr];
         ref_pix <= ref_mem[mem_addr];
      end
      if (mem_en8) begin
         cur_pix8 <= cur_mem[mem_addr8];
         ref_pix8 <= ref_mem[mem_addr8];
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_sad(input int sumw);
      int acc;
      int d;
      int max_val;
      acc     = 0;
      max_val = (1 << sumw) - 1;
      for (int k = 0; k < 16; k++) begin
         d = int'(cur_mem[k]) - int'(ref_mem[k]);
         if (d < 0) d = -d;
         acc += d;
         if (acc > max_val) acc = max_val;
      end
      return acc;
   endfunction

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done) begin
         check_value("sb_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            int exp_sad;
            exp_sad = sb_q.pop_front();
            check_value("sad", 32'(sad), 32'(exp_sad));
            $display("txn done: sad=%0d expected=%0d", sad, exp_sad);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check_value({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check_value({tag, "_busy"}, 32'(busy), 32'd0);
      check_value({tag, "_done"}, 32'(done), 32'd0);
      check_value({tag, "_sad"}, 32'(sad), 32'd0);
   endtask

   // Caller is at a negedge with the DUT idle. Each run is 18 cycles long.
   task automatic run_blocks(input string name, input int runs, input bit glitch);
      int exp_sad;
      exp_sad = model_sad(16);
      start = 1'b1;
      sb_q.push_back(exp_sad);
      for (int n = 1; n <= 18 * runs; n++) begin
         int p;
         p = ((n - 1) % 18) + 1;
         @(negedge clk);
         check_value({name, "_mem_en"}, 32'(mem_en), 32'(p <= 16));
         if (p <= 16) check_value({name, "_mem_addr"}, 32'(mem_addr), 32'(p - 1));
         check_value({name, "_busy"}, 32'(busy), 32'(p <= 17));
         check_value({name, "_done"}, 32'(done), 32'(p == 18));
         if (p == 18 && n < 18 * runs) sb_q.push_back(exp_sad);
         if (runs > 1) start = (n < 18 * runs);
         else          start = glitch && (p == 4 || p == 16 || p == 17);
      end
      @(negedge clk);
      check_value({name, "_idle_busy"}, 32'(busy), 32'd0);
      check_value({name, "_idle_done"}, 32'(done), 32'd0);
      $display("txn %s: runs=%0d expected_sad=%0d", name, runs, exp_sad);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      start8 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cur_mem[k] = 8'(k);
         ref_mem[k] = 8'(k);
      end
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      check_value("reset_done8", 32'(done8), 32'd0);
      check_value("reset_sad8", 32'(sad8), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_blocks("identical", 1, 1'b0);

      for (int k = 0; k < 16; k++) begin cur_mem[k] = 8'd255; ref_mem[k] = 8'd0; end
      run_blocks("cur_max", 1, 1'b0);

      for (int k = 0; k < 16; k++) begin cur_mem[k] = 8'd0; ref_mem[k] = 8'd255; end
      run_blocks("ref_max", 1, 1'b0);

      for (int k = 0; k < 16; k++) begin cur_mem[k] = 8'(k * 10); ref_mem[k] = 8'd100; end
      check_value("model_mixed", 32'(model_sad(16)), 32'd700);
      run_blocks("mixed", 1, 1'b0);

      for (int k = 0; k < 16; k++) begin
         cur_mem[k] = 8'($urandom_range(0, 255));
         ref_mem[k] = 8'($urandom_range(0, 255));
      end
      run_blocks("random_glitch", 1, 1'b1);

      for (int k = 0; k < 16; k++) begin cur_mem[k] = 8'(k * 10); ref_mem[k] = 8'd100; end
      run_blocks("back_to_back", 3, 1'b0);

      // Reset while the address counter is at 7; the queued result is abandoned.
      for (int k = 0; k < 16; k++) begin cur_mem[k] = 8'd255; ref_mem[k] = 8'd0; end
      start = 1'b1;
      sb_q.push_back(model_sad(16));
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check_value("prereset_mem_addr", 32'(mem_addr), 32'd7);
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("midrun_reset");
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check_value("postreset_done", 32'(done), 32'd0);
         check_value("postreset_busy", 32'(busy), 32'd0);
      end
      $display("txn midrun_reset: outputs cleared");
      run_blocks("after_reset", 1, 1'b0);

      // Narrow accumulator build saturates but keeps the same timing.
      start8 = 1'b1;
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         start8 = 1'b0;
         check_value("sat_done8", 32'(done8), 32'(n == 18));
         if (n == 18) check_value("sat_sad8", 32'(sad8), 32'(model_sad(8)));
      end
      $display("txn saturate: sad8=%0d expected=%0d", sad8, model_sad(8));

      repeat (2) @(negedge clk);
      check_value("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
